stream_demux6: RTL and testbench
================================

Name: stream_demux6

Overview:
- Registered 1-to-6 stream demultiplexer: the distribution counterpart of the 6-way data selector.
- Takes one 4-bit valid/ready input stream tagged with a 3-bit destination select and delivers each beat to exactly one of six output channels.
- Sits between a shared producer and per-lane consumers.
- Uses a single holding register with full throughput, plus drop accounting for out-of-range selects.

Parameters:
- DATA_W, 4, payload width.
- NUM_CH, 6, number of output channels; the select range is 0..NUM_CH-1.
- SEL_W, 3, select width.
- CNT_W, 8, drop counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid is also high.
- in_sel  input  SEL_W  destination channel for the beat.
- in_data  input  DATA_W  payload.
- out_valid  output  NUM_CH  one-hot (or zero) per-channel valid.
- out_ready  input  NUM_CH  per-channel consumer ready.
- out_data  output  DATA_W  shared payload bus, meaningful for the channel whose out_valid bit is high.
- drop_cnt  output  CNT_W  saturating count of beats dropped for out-of-range select.
- drop_pulse  output  1  one-cycle pulse, the cycle after a drop.

Behaviour:
- State:
  - hold_v (1 bit), hold_ch (SEL_W bits), hold_data (DATA_W bits).
  - drop_cnt.
  - drop_pulse register.
- Reset, when rst_n is low at a clk edge:
  - hold_v=0, hold_ch=0, hold_data=0.
  - drop_cnt=0, drop_pulse=0.
  - Resulting outputs: out_valid=0, out_data=0, in_ready=1 in the first cycle after reset.
  - Reset mid-transfer discards any held beat with no delivery.
  - in_ready is forced to 0 while rst_n is low.
- Output decode:
  - out_valid[i] = hold_v && (hold_ch == i).
  - out_data = hold_data.
  - out_valid is never more than one-hot.
- Drain:
  - fire_out = hold_v && out_ready[hold_ch].
  - Ready bits of non-targeted channels are ignored.
- Input acceptance:
  - in_ready = rst_n && (!hold_v || fire_out).
  - in_ready is combinational from out_ready (a pass-through ready path is intended).
  - acc = in_valid && in_ready.
- Hold register update, in priority order:
  - acc with in_sel < NUM_CH: hold_v=1, hold_ch=in_sel, hold_data=in_data. This is a load; a load in the same cycle as fire_out is back-to-back, giving full throughput with 1 beat/cycle sustained.
  - acc with in_sel >= NUM_CH (values 6 and 7): the beat is consumed and discarded.
    - hold_v becomes 0 if fire_out this cycle, otherwise it is unchanged (it must already have been 0 for acc).
    - drop_cnt increments, saturating at 2^CNT_W-1 (255); it never wraps.
    - drop_pulse=1 next cycle.
  - No acc and fire_out: hold_v=0; hold_ch and hold_data are unchanged.
  - Otherwise: all hold state unchanged.
- drop_pulse is 0 in every cycle not following a drop.
- Latency: an accepted beat appears on out_valid/out_data in the cycle after acceptance.
- Stability: while hold_v && !out_ready[hold_ch], hold_ch and hold_data must not change, and in_ready=0.
- No reordering: beats leave in acceptance order, because there is a single slot.
- The in_sel value is sampled only when acc; at other times it is don't-care.

Decomposition:
- Package stream_demux_pkg:
  - Constants NUM_CH=6, SEL_W=3, DATA_W=4, CNT_W=8.
  - Typedef ch_sel_t (logic [SEL_W-1:0]).
  - Typedef beat_t, a packed struct {ch_sel_t ch; logic [DATA_W-1:0] data}.
- Sub-module stream_demux_slot:
  - Holds the single-entry valid/ready register (hold_v plus beat_t).
  - Ports: load, drain, beat in/out.
- The top level owns decode, acceptance, and the drop counter and pulse.

Test Plan:
1. Reset, then apply in_valid=1, in_sel=2, in_data=4'hA with out_ready=6'b111111.
   - Next cycle: out_valid=6'b000100 and out_data=4'hA.
   - in_ready stays 1 throughout.
2. Back-to-back stream with sels 0,1,2,3,4,5 and data 1..6, all out_ready=1.
   - out_valid walks 000001→100000 with data 1..6 on consecutive cycles.
   - No bubbles; in_ready stays 1.
3. Backpressure: hold sel=3, data=4'h7 with out_ready[3]=0 for 4 cycles while the other ready bits are 1.
   - out_valid=6'b001000 and out_data=4'h7 stay stable.
   - in_ready=0.
   - Raise out_ready[3] and present sel=5, data=4'h9 in the same cycle: 4'h9 is accepted that cycle and appears on out_valid[5] the next cycle.
4. Invalid select: in_sel=6 then in_sel=7, in consecutive cycles.
   - Both beats are accepted and no out_valid is asserted.
   - drop_pulse is high on the two following cycles.
   - drop_cnt reaches 2.
   - Then drive 300 drops: drop_cnt saturates at 255.
5. Drop while draining: hold a beat for ch1, set out_ready[1]=1, and present in_sel=7 in the same cycle.
   - The ch1 beat delivers.
   - The slot goes empty the next cycle with out_valid=0.
   - drop_cnt increments.
6. Reset mid-operation: hold sel=4 with out_ready=0, then drive rst_n=0 for 1 cycle.
   - After reset: out_valid=0, drop_cnt=0, in_ready=1.
   - The held beat is never delivered.

Source files
------------

// File: rtl/stream_demux6_pkg.sv
// Shared constants and beat types for the 1-to-6 stream demultiplexer.
package stream_demux_pkg;

    localparam int NUM_CH = 6;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    typedef logic [SEL_W-1:0] ch_sel_t;

    typedef struct packed {
        ch_sel_t           ch;
        logic [DATA_W-1:0] data;
    } beat_t;

endpackage

// File: rtl/stream_demux6_if.sv
// Handshake bundle between the shared producer, the demux and the per-lane consumers.
interface stream_demux6_if;
    import stream_demux_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_W-1:0]      in_sel;
    logic [DATA_W-1:0]     in_data;
    logic [NUM_CH-1:0]     out_valid;
    logic [NUM_CH-1:0]     out_ready;
    logic [DATA_W-1:0]     out_data;

    // Demux side.
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    // Producer / consumer side.
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_demux6_slot.sv
// Single-entry holding register: a load always wins, otherwise a drain empties it.
module stream_demux_slot
    import stream_demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  logic  drain_i,
    input  beat_t beat_i,
    output logic  valid_o,
    output beat_t beat_o
);

    logic  valid_q, valid_d;
    beat_t beat_q,  beat_d;

    // Next state: load overwrites (covers back-to-back), drain clears the valid flag only.
    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (load_i) begin
            valid_d = 1'b1;
            beat_d  = beat_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot state; reset discards any held beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign valid_o = valid_q;
    assign beat_o  = beat_q;

endmodule

// File: rtl/stream_demux6.sv
// Registered 1-to-6 stream demux with out-of-range drop accounting.
module stream_demux6
    import stream_demux_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    stream_demux6_if.slave     bus,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               drop_pulse
);

    logic              hold_v;
    beat_t             hold;
    beat_t             in_beat;
    logic [NUM_CH-1:0] out_valid_w;
    logic              fire_out;
    logic              acc;
    logic              in_range;
    logic              load;
    logic              drop;

    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              drop_pulse_q;

    // One-hot decode of the held beat onto the per-channel valids.
    always_comb begin
        out_valid_w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            out_valid_w[i] = hold_v && (hold.ch == ch_sel_t'(i));
        end
    end

    // Only the targeted channel's ready can drain the slot.
    assign fire_out = |(out_valid_w & bus.out_ready);

    // Ready passes straight through from the consumer so the slot refills in the drain cycle.
    assign bus.in_ready = rst_n && (!hold_v || fire_out);
    assign acc          = bus.in_valid && bus.in_ready;
    assign in_range     = (bus.in_sel < ch_sel_t'(NUM_CH));
    assign load         = acc && in_range;
    assign drop         = acc && !in_range;

    assign in_beat.ch   = bus.in_sel;
    assign in_beat.data = bus.in_data;

    stream_demux_slot u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .drain_i (fire_out),
        .beat_i  (in_beat),
        .valid_o (hold_v),
        .beat_o  (hold)
    );

    // Saturating drop count: stops at all-ones instead of wrapping.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Drop counter and one-cycle drop indication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop;
        end
    end

    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = hold.data;
    assign drop_cnt      = drop_cnt_q;
    assign drop_pulse    = drop_pulse_q;

endmodule

// File: tb/tb_stream_demux6.sv
// Directed bench for stream_demux6: each step drives inputs, clocks, and checks hand-computed values.
module tb_stream_demux6;
    import stream_demux_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] drop_cnt;
    logic             drop_pulse;

    int n_cmp = 0;
    int n_err = 0;

    stream_demux6_if bus ();

    stream_demux6 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .drop_cnt   (drop_cnt),
        .drop_pulse (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational paths settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;

        // Reset
        settle();
        chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),      32'd0);
        chk("rst_drop_pulse",32'(drop_pulse),    32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Single beat to channel 2
        bus.out_ready = 6'b111111;
        drive(1'b1, 3'd2, 4'hA);
        settle();
        chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t1_out_valid", 32'(bus.out_valid), 32'b000100);
        chk("t1_out_data",  32'(bus.out_data),  32'hA);
        chk("t1_in_ready_after", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 3'd0, 4'h0);
        tick();
        chk("t1_drained", 32'(bus.out_valid), 32'd0);

        // Back-to-back walk over all channels
        for (int i = 0; i < NUM_CH; i++) begin
            drive(1'b1, SEL_W'(i), DATA_W'(i + 1));
            settle();
            chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            chk("t2_out_valid", 32'(bus.out_valid), 32'(1) << i);
            chk("t2_out_data",  32'(bus.out_data),  32'(i + 1));
        end
        drive(1'b0, 3'd0, 4'h0);
        tick();
        chk("t2_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure on channel 3 while the other channels are ready
        bus.out_ready = 6'b110111;
        drive(1'b1, 3'd3, 4'h7);
        tick();
        drive(1'b1, 3'd0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t3_in_ready_blocked", 32'(bus.in_ready), 32'd0);
            tick();
            chk("t3_hold_valid", 32'(bus.out_valid), 32'b001000);
            chk("t3_hold_data",  32'(bus.out_data),  32'h7);
        end
        bus.out_ready = 6'b111111;
        drive(1'b1, 3'd5, 4'h9);
        settle();
        chk("t3_in_ready_passthru", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t3_next_valid", 32'(bus.out_valid), 32'b100000);
        chk("t3_next_data",  32'(bus.out_data),  32'h9);
        drive(1'b0, 3'd0, 4'h0);
        tick();
        chk("t3_drained", 32'(bus.out_valid), 32'd0);

        // Out-of-range selects are consumed and counted
        drive(1'b1, 3'd6, 4'h1);
        settle();
        chk("t4_in_ready_sel6", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t4_no_valid_6", 32'(bus.out_valid), 32'd0);
        chk("t4_pulse_6",    32'(drop_pulse),    32'd1);
        chk("t4_cnt_1",      32'(drop_cnt),      32'd1);
        drive(1'b1, 3'd7, 4'h2);
        tick();
        chk("t4_no_valid_7", 32'(bus.out_valid), 32'd0);
        chk("t4_pulse_7",    32'(drop_pulse),    32'd1);
        chk("t4_cnt_2",      32'(drop_cnt),      32'd2);
        drive(1'b0, 3'd0, 4'h0);
        tick();
        chk("t4_pulse_gone", 32'(drop_pulse), 32'd0);
        chk("t4_cnt_hold",   32'(drop_cnt),   32'd2);
        drive(1'b1, 3'd7, 4'h3);
        repeat (252) tick();
        chk("t4_cnt_254", 32'(drop_cnt), 32'd254);
        repeat (48) tick();
        chk("t4_cnt_sat", 32'(drop_cnt), 32'd255);
        drive(1'b0, 3'd0, 4'h0);
        tick();
        chk("t4_cnt_sat_hold", 32'(drop_cnt),   32'd255);
        chk("t4_pulse_end",    32'(drop_pulse), 32'd0);

        // Reset while a beat is held
        bus.out_ready = 6'b000000;
        drive(1'b1, 3'd4, 4'h5);
        tick();
        chk("t6_held", 32'(bus.out_valid), 32'b010000);
        drive(1'b0, 3'd0, 4'h0);
        rst_n = 1'b0;
        settle();
        chk("t6_in_ready_in_rst", 32'(bus.in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_drop_cnt",  32'(drop_cnt),      32'd0);
        chk("t6_in_ready",  32'(bus.in_ready),  32'd1);
        bus.out_ready = 6'b111111;
        tick();
        chk("t6_never_delivered", 32'(bus.out_valid), 32'd0);

        // Drop accepted in the same cycle the held beat drains
        bus.out_ready = 6'b000000;
        drive(1'b1, 3'd1, 4'h3);
        tick();
        chk("t5_held", 32'(bus.out_valid), 32'b000010);
        chk("t5_held_data", 32'(bus.out_data), 32'h3);
        bus.out_ready = 6'b000010;
        drive(1'b1, 3'd7, 4'hC);
        settle();
        chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 3'd0, 4'h0);
        chk("t5_empty",  32'(bus.out_valid), 32'd0);
        chk("t5_cnt",    32'(drop_cnt),      32'd1);
        chk("t5_pulse",  32'(drop_pulse),    32'd1);
        tick();
        chk("t5_pulse_gone", 32'(drop_pulse), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
